bubble_host_sequencer: RTL and testbench

- Synthesizable host-side sequencer that generates the Bubble System host control waveforms: nBSEN (shift enable), nREPEN (replicator enable) and nBOOTEN (bootloop enable).
- Successor to the hand-timed bench stimulus: every interval, the replicator pulse shape and the page count are parametrised or run-time configurable.
- Adds boot-skip, abort and status outputs.
- Sits in the self-test / bench harness and drives BubbleDrive8_top host inputs directly.

---
 rtl/bubble_host_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_bubble_host_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bubble_host_sequencer.sv
// Host-side Bubble System sequencer: generates nBSEN/nREPEN/nBOOTEN with parametrised boot and page timing.
// All outputs registered; no backpressure, start honoured only in IDLE, abort wins over everything but reset.
module bubble_host_sequencer #(
    parameter int          TW         = 32,
    parameter int          PW         = 12,
    parameter int unsigned BOOT_WAIT  = 25000,
    parameter int unsigned BOOT_LEN   = 2193873,
    parameter int unsigned REP_OFS    = 19,
    parameter int unsigned REP_LO     = 342,
    parameter int unsigned REP_HI     = 618,
    parameter int unsigned BOOTEN_DLY = 212,
    parameter int unsigned PAGE_GAP   = 37500,
    parameter int unsigned PAGE_LEN   = 337830
) (
    input  logic          MCLK,
    input  logic          MRST,
    input  logic          start,
    input  logic          abort,
    input  logic          skip_boot,
    input  logic [PW-1:0] page_count,
    output logic          nBSEN,
    output logic          nREPEN,
    output logic          nBOOTEN,
    output logic          busy,
    output logic          done,
    output logic [PW-1:0] page_idx
);

    typedef enum logic [2:0] {
        S_IDLE, S_BOOT_WAIT, S_BOOT_SHIFT, S_BOOT_TAIL, S_PAGE_GAP, S_PAGE_SHIFT, S_FINISH
    } state_t;

    typedef enum logic [1:0] {R_OFS, R_LO, R_HI, R_OFF} rep_t;

    localparam logic [TW-1:0] C_BW = TW'(BOOT_WAIT - 1);
    localparam logic [TW-1:0] C_BL = TW'(BOOT_LEN - 1);
    localparam logic [TW-1:0] C_RO = TW'(REP_OFS - 1);
    localparam logic [TW-1:0] C_RL = TW'(REP_LO - 1);
    localparam logic [TW-1:0] C_RH = TW'(REP_HI - 1);
    localparam logic [TW-1:0] C_BD = TW'(BOOTEN_DLY - 1);
    localparam logic [TW-1:0] C_PG = TW'(PAGE_GAP - 1);
    localparam logic [TW-1:0] C_PL = TW'(PAGE_LEN - 1);

    state_t        state_q, state_d;
    rep_t          rep_q, rep_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] sub_q, sub_d;
    logic [PW-1:0] pc_q, pc_d;
    logic [PW-1:0] page_idx_q, page_idx_d;
    logic          nbsen_q, nbsen_d;
    logic          nrepen_q, nrepen_d;
    logic          nbooten_q, nbooten_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    always_comb begin
        state_d    = state_q;
        rep_d      = rep_q;
        cnt_d      = cnt_q;
        sub_d      = sub_q;
        pc_d       = pc_q;
        page_idx_d = page_idx_q;
        nbsen_d    = nbsen_q;
        nrepen_d   = nrepen_q;
        nbooten_d  = nbooten_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        // Replicator sub-sequencer; the window expiry below overrides it so a pulse can be truncated.
        if (state_q == S_BOOT_SHIFT || state_q == S_PAGE_SHIFT) begin
            unique case (rep_q)
                R_OFS: if (sub_q == C_RO) begin
                    nrepen_d = 1'b0;
                    sub_d    = '0;
                    rep_d    = R_LO;
                end else sub_d = sub_q + TW'(1);
                R_LO: if (sub_q == C_RL) begin
                    nrepen_d = 1'b1;
                    sub_d    = '0;
                    rep_d    = (state_q == S_BOOT_SHIFT) ? R_HI : R_OFF;
                end else sub_d = sub_q + TW'(1);
                R_HI: if (sub_q == C_RH) begin
                    nrepen_d = 1'b0;
                    sub_d    = '0;
                    rep_d    = R_LO;
                end else sub_d = sub_q + TW'(1);
                R_OFF: sub_d = sub_q;
            endcase
        end

        case (state_q)
            S_IDLE: if (start) begin
                pc_d       = page_count;
                page_idx_d = '0;
                busy_d     = 1'b1;
                cnt_d      = '0;
                if (!skip_boot) begin
                    state_d = S_BOOT_WAIT;
                end else begin
                    nbooten_d = 1'b1;
                    if (page_count == '0) begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_PAGE_GAP;
                    end
                end
            end
            S_BOOT_WAIT: if (cnt_q == C_BW) begin
                nbsen_d = 1'b0;
                cnt_d   = '0;
                sub_d   = '0;
                rep_d   = R_OFS;
                state_d = S_BOOT_SHIFT;
            end else cnt_d = cnt_q + TW'(1);
            S_BOOT_SHIFT: if (cnt_q == C_BL) begin
                nbsen_d  = 1'b1;
                nrepen_d = 1'b1;
                rep_d    = R_OFF;
                cnt_d    = '0;
                state_d  = S_BOOT_TAIL;
            end else cnt_d = cnt_q + TW'(1);
            S_BOOT_TAIL: if (cnt_q == C_BD) begin
                nbooten_d = 1'b1;
                cnt_d     = '0;
                if (pc_q == '0) begin
                    state_d = S_FINISH;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_PAGE_GAP;
                end
            end else cnt_d = cnt_q + TW'(1);
            S_PAGE_GAP: if (cnt_q == C_PG) begin
                nbsen_d = 1'b0;
                cnt_d   = '0;
                sub_d   = '0;
                rep_d   = R_OFS;
                state_d = S_PAGE_SHIFT;
            end else cnt_d = cnt_q + TW'(1);
            S_PAGE_SHIFT: if (cnt_q == C_PL) begin
                nbsen_d  = 1'b1;
                nrepen_d = 1'b1;
                rep_d    = R_OFF;
                cnt_d    = '0;
                if (page_idx_q == pc_q - PW'(1)) begin
                    state_d = S_FINISH;
                    done_d  = 1'b1;
                end else begin
                    page_idx_d = page_idx_q + PW'(1);
                    state_d    = S_PAGE_GAP;
                end
            end else cnt_d = cnt_q + TW'(1);
            S_FINISH: begin
                state_d   = S_IDLE;
                busy_d    = 1'b0;
                nbooten_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        // page_idx is deliberately left alone so the last index stays visible after an abort.
        if (abort) begin
            state_d   = S_IDLE;
            rep_d     = R_OFF;
            cnt_d     = '0;
            sub_d     = '0;
            nbsen_d   = 1'b1;
            nrepen_d  = 1'b1;
            nbooten_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge MCLK or negedge MRST) begin
        if (!MRST) begin
            state_q    <= S_IDLE;
            rep_q      <= R_OFF;
            cnt_q      <= '0;
            sub_q      <= '0;
            pc_q       <= '0;
            page_idx_q <= '0;
            nbsen_q    <= 1'b1;
            nrepen_q   <= 1'b1;
            nbooten_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rep_q      <= rep_d;
            cnt_q      <= cnt_d;
            sub_q      <= sub_d;
            pc_q       <= pc_d;
            page_idx_q <= page_idx_d;
            nbsen_q    <= nbsen_d;
            nrepen_q   <= nrepen_d;
            nbooten_q  <= nbooten_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign nBSEN    = nbsen_q;
    assign nREPEN   = nrepen_q;
    assign nBOOTEN  = nbooten_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign page_idx = page_idx_q;

endmodule

// File: tb/tb_bubble_host_sequencer.sv
// Bench for bubble_host_sequencer: expected edge times per output are queued at start and matched as edges appear.
module tb_bubble_host_sequencer;

    localparam int P_PW = 12;
    localparam int P_BW = 10;
    localparam int P_BL = 100;
    localparam int P_RO = 3;
    localparam int P_RL = 4;
    localparam int P_RH = 6;
    localparam int P_BD = 5;
    localparam int P_PG = 8;
    localparam int P_PL = 20;
    localparam int P_BL_T = 25;
    localparam int NS = 5;

    logic MCLK = 1'b0;
    logic MRST, start, abort, skip_boot;
    logic [P_PW-1:0] page_count;
    logic nBSEN, nREPEN, nBOOTEN, busy, done;
    logic [P_PW-1:0] page_idx;
    logic t_nBSEN, t_nREPEN, t_nBOOTEN, t_busy, t_done;
    logic [P_PW-1:0] t_page_idx;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    int unsigned expq [NS][$];
    logic [NS-1:0] prev_s = '0;
    logic [NS-1:0] cur_s;
    string sname [NS] = '{"nBSEN_edge", "nREPEN_edge", "nBOOTEN_edge", "done_edge", "busy_edge"};

    always #5 MCLK = ~MCLK;
    always @(posedge MCLK) cyc <= cyc + 1;

    bubble_host_sequencer #(
        .TW(32), .PW(P_PW), .BOOT_WAIT(P_BW), .BOOT_LEN(P_BL), .REP_OFS(P_RO), .REP_LO(P_RL),
        .REP_HI(P_RH), .BOOTEN_DLY(P_BD), .PAGE_GAP(P_PG), .PAGE_LEN(P_PL)
    ) dut (
        .MCLK(MCLK), .MRST(MRST), .start(start), .abort(abort), .skip_boot(skip_boot),
        .page_count(page_count), .nBSEN(nBSEN), .nREPEN(nREPEN), .nBOOTEN(nBOOTEN),
        .busy(busy), .done(done), .page_idx(page_idx)
    );

    // Same timing except a short boot window whose expiry lands inside a replicator pulse.
    bubble_host_sequencer #(
        .TW(32), .PW(P_PW), .BOOT_WAIT(P_BW), .BOOT_LEN(P_BL_T), .REP_OFS(P_RO), .REP_LO(P_RL),
        .REP_HI(P_RH), .BOOTEN_DLY(P_BD), .PAGE_GAP(P_PG), .PAGE_LEN(P_PL)
    ) dut_t (
        .MCLK(MCLK), .MRST(MRST), .start(start), .abort(abort), .skip_boot(skip_boot),
        .page_count(page_count), .nBSEN(t_nBSEN), .nREPEN(t_nREPEN), .nBOOTEN(t_nBOOTEN),
        .busy(t_busy), .done(t_done), .page_idx(t_page_idx)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NS; i++) if (expq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic flush();
        for (int i = 0; i < NS; i++) expq[i].delete();
    endtask

    always @(negedge MCLK) begin
        cur_s = {busy, done, nBOOTEN, nREPEN, nBSEN};
        if (mon_en) begin
            for (int i = 0; i < NS; i++) begin
                if (cur_s[i] !== prev_s[i]) begin
                    if (expq[i].size() == 0) check({sname[i], "_unexpected"}, cyc, -1);
                    else check(sname[i], cyc, expq[i].pop_front());
                end
            end
        end
        prev_s = cur_s;
    end

    // Expected edge cycles derived from the interval definitions, for a start sampled at edge s.
    task automatic gen_expect(input int s, input bit skip, input int pc);
        int t, f, e, r;
        expq[4].push_back(s);
        if (!skip) begin
            f = s + P_BW;
            e = f + P_BL;
            expq[0].push_back(f);
            r = f + P_RO;
            while (r < e) begin
                expq[1].push_back(r);
                expq[1].push_back((r + P_RL < e) ? r + P_RL : e);
                r += P_RL + P_RH;
            end
            expq[0].push_back(e);
            t = e + P_BD;
        end else begin
            t = s;
        end
        expq[2].push_back(t);
        for (int p = 0; p < pc; p++) begin
            f = t + P_PG;
            e = f + P_PL;
            expq[0].push_back(f);
            if (P_RO < P_PL) begin
                expq[1].push_back(f + P_RO);
                expq[1].push_back((f + P_RO + P_RL < e) ? f + P_RO + P_RL : e);
            end
            expq[0].push_back(e);
            t = e;
        end
        expq[3].push_back(t);
        expq[3].push_back(t + 1);
        expq[2].push_back(t + 1);
        expq[4].push_back(t + 1);
    endtask

    task automatic start_run(input bit skip, input int pc, output int s);
        @(negedge MCLK);
        start = 1'b1;
        skip_boot = skip;
        page_count = P_PW'(pc);
        s = cyc + 1;
        gen_expect(s, skip, pc);
        @(negedge MCLK);
        start = 1'b0;
        skip_boot = ~skip;
        page_count = P_PW'($urandom);
    endtask

    task automatic to_cyc(input int c);
        while (cyc < c) @(negedge MCLK);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!all_empty() && n < budget) begin
            @(negedge MCLK);
            n++;
        end
        check("run_complete", all_empty(), 1);
        flush();
        repeat (4) @(negedge MCLK);
    endtask

    initial begin
        assert (P_BW >= 1 && P_BL >= 1 && P_BL_T >= 1 && P_RO >= 1 && P_RL >= 1 && P_RH >= 1 &&
                P_BD >= 1 && P_PG >= 1 && P_PL >= 1)
            else $fatal(1, "FAIL params: every timing parameter must be at least 1");
    end

    initial begin
        int s;
        int dcount;
        MRST = 1'b0; start = 1'b0; abort = 1'b0; skip_boot = 1'b0; page_count = '0;
        @(negedge MCLK);
        check("rst_nBSEN", nBSEN, 1);
        check("rst_nREPEN", nREPEN, 1);
        check("rst_nBOOTEN", nBOOTEN, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_page_idx", page_idx, 0);
        MRST = 1'b1;
        repeat (2) @(negedge MCLK);
        #1 mon_en = 1'b1;

        // Full boot + 2 pages; a start pulse mid-run must not disturb timing.
        start_run(1'b0, 2, s);
        to_cyc(s + 34);
        check("trunc_pre_nBSEN", t_nBSEN, 0);
        check("trunc_pre_nREPEN", t_nREPEN, 0);
        to_cyc(s + 35);
        check("trunc_nBSEN_rise", t_nBSEN, 1);
        check("trunc_nREPEN_forced", t_nREPEN, 1);
        to_cyc(s + 40);
        check("trunc_nBOOTEN", t_nBOOTEN, 1);
        to_cyc(s + 50);
        start = 1'b1; skip_boot = 1'b1; page_count = '0;
        @(negedge MCLK);
        start = 1'b0;
        wait_idle(400);
        check("run1_page_idx", page_idx, 1);
        check("run1_busy", busy, 0);

        // Boot skipped, 3 pages.
        start_run(1'b1, 3, s);
        wait_idle(300);
        check("run2_page_idx", page_idx, 2);

        // Zero pages with boot skipped; page_idx cleared by start.
        start_run(1'b1, 0, s);
        wait_idle(10);
        check("run3_page_idx", page_idx, 0);

        // Abort during the first boot-phase replicator low.
        start_run(1'b0, 1, s);
        to_cyc(s + 13);
        #1 mon_en = 1'b0;
        flush();
        check("abort_pre_nREPEN", nREPEN, 0);
        abort = 1'b1;
        @(negedge MCLK);
        abort = 1'b0;
        check("abort_nBSEN", nBSEN, 1);
        check("abort_nREPEN", nREPEN, 1);
        check("abort_nBOOTEN", nBOOTEN, 0);
        check("abort_busy", busy, 0);
        dcount = 0;
        for (int i = 0; i < 10; i++) begin
            if (done === 1'b1 || nBSEN !== 1'b1) dcount++;
            @(negedge MCLK);
        end
        check("abort_quiet", dcount, 0);
        abort = 1'b1; start = 1'b1; skip_boot = 1'b1; page_count = '0;
        @(negedge MCLK);
        abort = 1'b0; start = 1'b0;
        check("abort_start_busy", busy, 0);
        check("abort_start_nBOOTEN", nBOOTEN, 0);
        check("abort_start_done", done, 0);
        repeat (2) @(negedge MCLK);
        #1 mon_en = 1'b1;
        start_run(1'b0, 1, s);
        wait_idle(300);
        check("run4_page_idx", page_idx, 0);

        // Asynchronous reset in the middle of a page window.
        start_run(1'b1, 2, s);
        to_cyc(s + 13);
        #2 mon_en = 1'b0;
        flush();
        check("prerst_nBSEN", nBSEN, 0);
        MRST = 1'b0;
        #1;
        check("arst_nBSEN", nBSEN, 1);
        check("arst_nREPEN", nREPEN, 1);
        check("arst_nBOOTEN", nBOOTEN, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_page_idx", page_idx, 0);
        @(negedge MCLK);
        MRST = 1'b1;
        repeat (2) @(negedge MCLK);
        #1 mon_en = 1'b1;
        start_run(1'b1, 1, s);
        wait_idle(100);
        check("run5_page_idx", page_idx, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
